// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: one imem read per FETCH entry, and a
// next-PC update per WRITE entry with misaligned-target detection.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      state,
    input  logic            branch_uc,
    input  logic            branch_c,
    input  logic            branch_relative,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_raw,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_done,
    output logic            fault
);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StHalt} fsm_e;

    localparam logic [2:0] PhaseFetch = 3'd0;
    localparam logic [2:0] PhaseWrite = 3'd4;

    fsm_e            fsm_q;
    logic [2:0]      prev_state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] instr_q;
    logic            req_q;
    logic            done_q;
    logic            fault_q;
    logic            fetch_entry;
    logic            write_entry;
    logic            misaligned;

    assign fetch_entry = (state == PhaseFetch) && (prev_state_q != PhaseFetch);
    assign write_entry = (state == PhaseWrite) && (prev_state_q != PhaseWrite);

    always_comb begin
        pc_d = pc_q + XLEN'(32'd4);
        if (branch_uc && !branch_relative) begin
            pc_d = {alu_result[XLEN-1:1], 1'b0};
        end else if (branch_uc || (branch_c && branch_taken)) begin
            pc_d = pc_q + imm;
        end
    end

    assign misaligned = (pc_d[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= StIdle;
            prev_state_q <= 3'd7;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            instr_q      <= '0;
            req_q        <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            prev_state_q <= state;
            done_q       <= 1'b0;
            case (fsm_q)
                StIdle: begin
                    if (fetch_entry && !fault_q) begin
                        fsm_q  <= StReq;
                        req_q  <= 1'b1;
                        addr_q <= pc_q;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        fsm_q   <= StDone;
                    end
                end
                StDone:  fsm_q <= StIdle;
                StHalt:  fsm_q <= StHalt;
                default: fsm_q <= StIdle;
            endcase
            // A fault overrides any fetch activity decided above on the same edge.
            if (write_entry && (fsm_q != StHalt)) begin
                if (misaligned) begin
                    fault_q <= 1'b1;
                    fsm_q   <= StHalt;
                    req_q   <= 1'b0;
                    done_q  <= 1'b0;
                end else begin
                    pc_q <= pc_d;
                end
            end
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign instr_raw  = instr_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + XLEN'(32'd4);
    assign fetch_done = done_q;
    assign fault      = fault_q;

endmodule
